// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, default datapath widths and the
// occupancy state type used by the issue stage.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_MUL     = 4'd7;
  localparam logic [3:0] ALU_EQ      = 4'd8;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the issue funct field into the ALU control code;
// unknown functs map to the illegal code so the ALU produces zero.
module alu_ctrl_decode (
  input  logic [3:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);
  import cpu_pkg::*;

  always_comb begin
    alu_ctrl = funct;
    illegal  = 1'b0;
    if (funct > ALU_EQ) begin
      alu_ctrl = ALU_ILLEGAL;
      illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding the ALU: decodes, selects/forwards operands and holds up
// to two ops (head + skid) behind valid/ready handshakes on both sides.
module alu_issue_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int IMM_W  = cpu_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_funct,
  input  logic              in_use_imm,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] fwd_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
);
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0]        alu_ctrl;
    logic              illegal;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
  } entry_t;

  occ_state_e state_q, state_d;
  entry_t     head_q, skid_q, cap_entry;
  logic       in_ready_q;
  logic       accept, consume;
  logic       head_from_in, head_from_skid, skid_load;
  logic [3:0] cap_ctrl;
  logic       cap_illegal;
  logic       fwd_a, fwd_b;
  logic [DATA_W-1:0] imm_sext;

  alu_ctrl_decode u_decode (
    .funct    (in_funct),
    .alu_ctrl (cap_ctrl),
    .illegal  (cap_illegal)
  );

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  // The head's result is still on fwd_result even in the cycle it is consumed.
  assign fwd_a    = out_valid & (in_rs1 != '0) & (in_rs1 == head_q.rd);
  assign fwd_b    = out_valid & (in_rs2 != '0) & (in_rs2 == head_q.rd);
  assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    cap_entry.alu_ctrl = cap_ctrl;
    cap_entry.illegal  = cap_illegal;
    cap_entry.a        = fwd_a ? fwd_result : in_rs1_data;
    cap_entry.b        = in_use_imm ? imm_sext : (fwd_b ? fwd_result : in_rs2_data);
    cap_entry.rd       = in_rd;
  end

  always_comb begin
    state_d        = state_q;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          head_from_in = 1'b1;
        end
      end
      ONE: begin
        case ({accept, consume})
          2'b10: begin
            state_d   = TWO;
            skid_load = 1'b1;
          end
          2'b01:   state_d      = EMPTY;
          2'b11:   head_from_in = 1'b1;
          default: state_d      = ONE;
        endcase
      end
      TWO: begin
        if (consume) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (head_from_in)
        head_q <= cap_entry;
      else if (head_from_skid)
        head_q <= skid_q;
      if (skid_load)
        skid_q <= cap_entry;
    end
  end

  assign out_alu_ctrl = head_q.alu_ctrl;
  assign out_illegal  = head_q.illegal;
  assign out_a        = head_q.a;
  assign out_b        = head_q.b;
  assign out_rd       = head_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic
// compared every cycle against a queue-based model of the stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_funct;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, fwd_result;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct     (in_funct),
    .in_use_imm   (in_use_imm),
    .in_imm       (in_imm),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .fwd_result   (fwd_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic        illegal;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_op_t;

  exp_op_t model_q[$];
  int      checks_total  = 0;
  int      checks_passed = 0;
  int      model_accepts = 0;
  bit      cmp_en        = 1'b0;

  task automatic checkOutput(input string name, input logic [75:0] actual, input logic [75:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] funct, input bit use_imm,
                               input logic [15:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] fwd);
    in_valid    = v;
    in_funct    = funct;
    in_use_imm  = use_imm;
    in_imm      = imm;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_rs1_data = d1;
    in_rs2_data = d2;
    fwd_result  = fwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of at most two ops; the front is what the ALU must see.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin : model_step
      exp_op_t n;
      bit      hv, acc, cons;
      hv   = (model_q.size() > 0);
      acc  = in_valid && (model_q.size() < 2);
      cons = hv && out_ready;
      if (acc) begin
        n.illegal = (in_funct > 4'd8);
        n.ctrl    = n.illegal ? 4'hF : in_funct;
        n.a       = (hv && in_rs1 != 5'd0 && in_rs1 == model_q[0].rd) ? fwd_result : in_rs1_data;
        if (in_use_imm)
          n.b = {{16{in_imm[15]}}, in_imm};
        else
          n.b = (hv && in_rs2 != 5'd0 && in_rs2 == model_q[0].rd) ? fwd_result : in_rs2_data;
        n.rd = in_rd;
      end
      if (cons) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(n);
        model_accepts++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin : cmp_step
      logic [75:0] act, expv;
      if (model_q.size() > 0) begin
        expv = {1'b1, (model_q.size() < 2), model_q[0].ctrl, model_q[0].illegal,
                model_q[0].a, model_q[0].b, model_q[0].rd};
        act  = {out_valid, in_ready, out_alu_ctrl, out_illegal, out_a, out_b, out_rd};
      end else begin
        expv = {1'b0, 1'b1, 74'd0};
        act  = {out_valid, in_ready, 74'd0};
      end
      checkOutput("cycle", act, expv);
    end
  end

  initial begin
    int cycles;
    int target;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(0, 4'd0, 0, 16'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 76'(out_valid), 76'd0);
    checkOutput("rst_ready", 76'(in_ready), 76'd1);
    checkOutput("rst_data", {out_alu_ctrl, out_illegal, out_a, out_b, out_rd}, 76'd0);
    @(negedge clk);
    rst_n  = 1'b0;
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic ADD, single cycle of validity
    out_ready = 1'b1;
    applyStimulus(1, 4'd0, 0, 16'd0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("add_valid", 76'(out_valid), 76'd1);
    checkOutput("add_fields", {out_alu_ctrl, out_a, out_b, out_rd}, {4'd0, 32'd5, 32'd7, 5'd4});
    tick();
    @(negedge clk);
    checkOutput("add_gone", 76'(out_valid), 76'd0);

    // Backpressure: two buffered, third refused, order preserved
    out_ready = 1'b0;
    applyStimulus(1, 4'd1, 0, 16'd0, 5'd1, 5'd2, 5'd5, 32'h11, 32'h1, 32'd0);
    tick();
    applyStimulus(1, 4'd2, 0, 16'd0, 5'd1, 5'd2, 5'd6, 32'h22, 32'h2, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_low", 76'(in_ready), 76'd0);
    checkOutput("bp_head", {out_alu_ctrl, out_a, out_rd}, {4'd1, 32'h11, 5'd5});
    applyStimulus(1, 4'd3, 0, 16'd0, 5'd1, 5'd2, 5'd7, 32'h33, 32'h3, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_hold", {in_ready, out_a, out_rd}, {1'b0, 32'h11, 5'd5});
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("bp_second", {out_valid, out_alu_ctrl, out_a, out_rd}, {1'b1, 4'd2, 32'h22, 5'd6});
    tick();
    @(negedge clk);
    checkOutput("bp_drained", 76'(out_valid), 76'd0);

    // Forwarding from head, including when head is consumed in the same cycle
    out_ready = 1'b0;
    applyStimulus(1, 4'd0, 0, 16'd0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    applyStimulus(1, 4'd0, 0, 16'd0, 5'd3, 5'd3, 5'd0, 32'd0, 32'd0, 32'h1234);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fwd_ab", {out_valid, out_a, out_b, out_rd}, {1'b1, 32'h1234, 32'h1234, 5'd0});
    applyStimulus(1, 4'd0, 0, 16'd0, 5'd0, 5'd0, 5'd9, 32'hABCD, 32'h77, 32'h5555);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fwd_zero_reg", {out_a, out_b}, {32'hABCD, 32'h77});
    tick();
    applyStimulus(1, 4'd0, 0, 16'd0, 5'd9, 5'd1, 5'd2, 32'h42, 32'h1, 32'h999);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fwd_stale_rd", 76'(out_a), 76'h42);

    // Immediates and decode boundaries
    applyStimulus(1, 4'd12, 1, 16'hFFFE, 5'd1, 5'd0, 5'd1, 32'd1, 32'd3, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("imm_neg_illegal", {out_alu_ctrl, out_illegal, out_b}, {4'hF, 1'b1, 32'hFFFF_FFFE});
    applyStimulus(1, 4'd8, 1, 16'h7FFF, 5'd1, 5'd0, 5'd1, 32'd1, 32'd3, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("imm_pos_eq", {out_alu_ctrl, out_illegal, out_b}, {4'h8, 1'b0, 32'h0000_7FFF});
    tick();

    // Asynchronous reset with both entries occupied
    out_ready = 1'b0;
    applyStimulus(1, 4'd4, 0, 16'd0, 5'd1, 5'd2, 5'd10, 32'h5A, 32'hA5, 32'd0);
    tick();
    applyStimulus(1, 4'd5, 0, 16'd0, 5'd1, 5'd2, 5'd11, 32'h6B, 32'hB6, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_full", {out_valid, in_ready}, {1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_flags", {out_valid, in_ready}, {1'b0, 1'b1});
    checkOutput("mid_rst_data", {out_alu_ctrl, out_illegal, out_a, out_b, out_rd}, 76'd0);
    #1 rst_n = 1'b1;

    // Random traffic against the model
    target = model_accepts + 10000;
    cycles = 0;
    tick();
    while (model_accepts < target && cycles < 60000) begin
      applyStimulus(($urandom_range(3) != 0), 4'($urandom_range(15)), ($urandom_range(3) == 0),
                    16'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                    5'($urandom_range(7)), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("rand_completed", 76'(model_accepts >= target), 76'd1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("final_empty", {out_valid, in_ready}, {1'b0, 1'b1});

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
